// File: rtl/game_pkg.sv
// Shared types and helpers for the memory game: player FSM states, pattern
// geometry and small decode functions used by the round logic.
package game_pkg;

  localparam int MAX_STEPS = 16;
  localparam int STEP_W    = 3;
  localparam int LEN_W     = 5;
  localparam int PAT_W     = MAX_STEPS * STEP_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW_ON,
    ST_SHOW_GAP,
    ST_INPUT,
    ST_DONE
  } player_state_t;

  function automatic logic [7:0] onehot8(input logic [STEP_W-1:0] idx);
    return 8'b1 << idx;
  endfunction

  function automatic logic [STEP_W-1:0] step_at(input logic [PAT_W-1:0] pat,
                                                input logic [3:0]       idx);
    return pat[idx*STEP_W +: STEP_W];
  endfunction

  // Out-of-range lengths (0 or above MAX_STEPS) play a full-length round.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len == '0 || len > LEN_W'(MAX_STEPS)) ? LEN_W'(MAX_STEPS) : len;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for the button levels followed by a rising-edge
// detector; the edge register runs continuously regardless of game state.
module btn_edge_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn_in,
  output logic [W-1:0] btn_sync,
  output logic [W-1:0] btn_rise
);

  logic [W-1:0] meta_q, sync_q, prev_q;
  logic [W-1:0] meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = btn_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign btn_sync = sync_q;
  assign btn_rise = sync_q & ~prev_q;

endmodule

// File: rtl/pattern_player.sv
// Round executor: latches a pattern, plays it on the LEDs, then checks the
// player's button presses step by step and reports the round result.
module pattern_player
  import game_pkg::*;
#(
  parameter int SHOW_TICKS    = 25_000_000,
  parameter int GAP_TICKS     = 12_500_000,
  parameter int TIMEOUT_TICKS = 250_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [PAT_W-1:0] pattern_flat,
  input  logic [7:0]       buttons,
  output logic [7:0]       leds,
  output logic             busy,
  output logic             round_done,
  output logic [LEN_W-1:0] correct_cnt,
  output logic             mistake,
  output logic             timeout
);

  localparam int MAX_SG    = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int MAX_TICKS = (MAX_SG > TIMEOUT_TICKS) ? MAX_SG : TIMEOUT_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS) + 1;

  // Counters are loaded with N-1 and the phase ends on the edge seen at zero,
  // which gives exactly N cycles per phase.
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_TICKS - 1);

  logic [7:0] btn_sync, btn_rise;

  btn_edge_sync #(.W(8)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (buttons),
    .btn_sync(btn_sync),
    .btn_rise(btn_rise)
  );

  player_state_t    state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [7:0]       leds_q, leds_d;
  logic             busy_q, busy_d;
  logic             round_done_q, round_done_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             mistake_q, mistake_d;
  logic             timeout_q, timeout_d;

  logic             single_rise;
  logic [7:0]       expected_btn;
  logic [LEN_W-1:0] idx_next;

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    len_d        = len_q;
    idx_d        = idx_q;
    tick_d       = tick_q;
    leds_d       = leds_q;
    busy_d       = busy_q;
    round_done_d = 1'b0;
    cnt_d        = cnt_q;
    mistake_d    = mistake_q;
    timeout_d    = timeout_q;

    single_rise  = (btn_rise != 8'd0) && ((btn_rise & (btn_rise - 8'd1)) == 8'd0);
    expected_btn = onehot8(step_at(pattern_q, idx_q[3:0]));
    idx_next     = idx_q + LEN_W'(1);

    case (state_q)
      ST_IDLE: begin
        leds_d = 8'd0;
        busy_d = 1'b0;
        if (start) begin
          pattern_d = pattern_flat;
          len_d     = clamp_len(length);
          cnt_d     = '0;
          mistake_d = 1'b0;
          timeout_d = 1'b0;
          idx_d     = '0;
          tick_d    = SHOW_LOAD;
          leds_d    = onehot8(pattern_flat[STEP_W-1:0]);
          busy_d    = 1'b1;
          state_d   = ST_SHOW_ON;
        end
      end

      ST_SHOW_ON: begin
        if (tick_q == '0) begin
          tick_d  = GAP_LOAD;
          leds_d  = 8'd0;
          state_d = ST_SHOW_GAP;
        end else begin
          tick_d = tick_q - CNT_W'(1);
        end
      end

      ST_SHOW_GAP: begin
        if (tick_q == '0) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            idx_d   = '0;
            tick_d  = TO_LOAD;
            leds_d  = btn_sync;
            state_d = ST_INPUT;
          end else begin
            idx_d   = idx_next;
            tick_d  = SHOW_LOAD;
            leds_d  = onehot8(step_at(pattern_q, idx_next[3:0]));
            state_d = ST_SHOW_ON;
          end
        end else begin
          tick_d = tick_q - CNT_W'(1);
        end
      end

      ST_INPUT: begin
        leds_d = btn_sync;
        // A press event always takes priority over an expiring timeout.
        if (btn_rise != 8'd0) begin
          if (single_rise && btn_rise == expected_btn) begin
            cnt_d  = cnt_q + LEN_W'(1);
            idx_d  = idx_next;
            tick_d = TO_LOAD;
            if (idx_next == len_q) begin
              round_done_d = 1'b1;
              leds_d       = 8'd0;
              state_d      = ST_DONE;
            end
          end else begin
            mistake_d    = 1'b1;
            round_done_d = 1'b1;
            leds_d       = 8'd0;
            state_d      = ST_DONE;
          end
        end else if (tick_q == '0) begin
          timeout_d    = 1'b1;
          round_done_d = 1'b1;
          leds_d       = 8'd0;
          state_d      = ST_DONE;
        end else begin
          tick_d = tick_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        leds_d  = 8'd0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        leds_d  = 8'd0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pattern_q    <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      tick_q       <= '0;
      leds_q       <= '0;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      cnt_q        <= '0;
      mistake_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      tick_q       <= tick_d;
      leds_q       <= leds_d;
      busy_q       <= busy_d;
      round_done_q <= round_done_d;
      cnt_q        <= cnt_d;
      mistake_q    <= mistake_d;
      timeout_q    <= timeout_d;
    end
  end

  assign leds        = leds_q;
  assign busy        = busy_q;
  assign round_done  = round_done_q;
  assign correct_cnt = cnt_q;
  assign mistake     = mistake_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_pattern_player.sv
// Randomised self-checking bench for pattern_player against a step-list
// reference model of the round rules.
module tb_pattern_player;

  localparam int S = 4;
  localparam int G = 2;
  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  length = 5'd0;
  logic [47:0] pattern_flat = 48'd0;
  logic [7:0]  buttons = 8'd0;
  logic [7:0]  leds;
  logic        busy, round_done, mistake, timeout;
  logic [4:0]  correct_cnt;

  int tests = 0;
  int fails = 0;

  pattern_player #(
    .SHOW_TICKS(S), .GAP_TICKS(G), .TIMEOUT_TICKS(T)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .pattern_flat(pattern_flat), .buttons(buttons), .leds(leds), .busy(busy),
    .round_done(round_done), .correct_cnt(correct_cnt), .mistake(mistake),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] oh(input int v);
    return 8'(1 << v);
  endfunction

  function automatic int eff_len(input int l);
    return (l == 0 || l > 16) ? 16 : l;
  endfunction

  function automatic logic [47:0] rand_pat();
    logic [47:0] p;
    p[31:0]  = $urandom();
    p[47:32] = 16'($urandom());
    return p;
  endfunction

  task automatic start_round(input logic [47:0] pat, input logic [4:0] len, input string tag);
    pattern_flat = pat;
    length = len;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    tests++;
    if (busy !== 1'b1 || correct_cnt !== 5'd0 || mistake !== 1'b0 || timeout !== 1'b0 || round_done !== 1'b0) begin
      fails++;
      $display("FAIL %s start: busy=%0b cnt=%0d mis=%0b to=%0b done=%0b, expected busy=1 others 0",
               tag, busy, correct_cnt, mistake, timeout, round_done);
    end
  endtask

  // Expected LED trace: each step lit S cycles then dark G cycles.
  task automatic check_show(input logic [47:0] pat, input int len, input bit disturb, input string tag);
    int total;
    int j;
    logic [7:0] exp;
    total = len * (S + G);
    j = 0;
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < S + G; c++) begin
        @(negedge clk);
        exp = (c < S) ? oh(int'(pat[3*i +: 3])) : 8'd0;
        tests++;
        if (leds !== exp || busy !== 1'b1) begin
          fails++;
          $display("FAIL %s show step %0d cyc %0d: leds=%h busy=%0b, expected leds=%h busy=1",
                   tag, i, c, leds, busy, exp);
        end
        if (disturb) begin
          if (j < total - 5) buttons = 8'($urandom());
          else               buttons = oh(int'(pat[2:0]));
          if (j == 3) begin
            start = 1'b1;
            pattern_flat = ~pat;
            length = 5'd2;
          end else begin
            start = 1'b0;
          end
        end
        j++;
      end
    end
    start = 1'b0;
    pattern_flat = pat;
    @(posedge clk);
    #1;
  endtask

  task automatic do_press(input logic [7:0] mask, input int cnt_before, input int cnt_after,
                          input bit exp_mis, input bit ends, input string tag);
    buttons = mask;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (correct_cnt !== 5'(cnt_before) || round_done !== 1'b0) begin
      fails++;
      $display("FAIL %s early: cnt=%0d done=%0b, expected cnt=%0d done=0",
               tag, correct_cnt, round_done, cnt_before);
    end
    @(posedge clk);
    #1;
    tests++;
    if (correct_cnt !== 5'(cnt_after) || mistake !== exp_mis || timeout !== 1'b0 || round_done !== ends) begin
      fails++;
      $display("FAIL %s eval: cnt=%0d mis=%0b to=%0b done=%0b, expected cnt=%0d mis=%0b to=0 done=%0b",
               tag, correct_cnt, mistake, timeout, round_done, cnt_after, exp_mis, ends);
    end
    if (!ends) begin
      tests++;
      if (leds !== mask) begin
        fails++;
        $display("FAIL %s echo: leds=%h expected %h", tag, leds, mask);
      end
    end
    buttons = 8'd0;
    @(posedge clk);
    #1;
    tests++;
    if (round_done !== 1'b0 || busy !== !ends || correct_cnt !== 5'(cnt_after) || mistake !== exp_mis) begin
      fails++;
      $display("FAIL %s after: done=%0b busy=%0b cnt=%0d mis=%0b, expected done=0 busy=%0b cnt=%0d mis=%0b",
               tag, round_done, busy, correct_cnt, mistake, !ends, cnt_after, exp_mis);
    end
  endtask

  // Timeout fires exactly T edges after the last reload; elapsed edges already consumed.
  task automatic do_idle(input int elapsed, input int cnt_exp, input string tag);
    for (int k = elapsed + 1; k < T; k++) begin
      @(posedge clk);
      #1;
      tests++;
      if (timeout !== 1'b0 || round_done !== 1'b0) begin
        fails++;
        $display("FAIL %s early timeout at %0d: to=%0b done=%0b, expected 0 0", tag, k, timeout, round_done);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (timeout !== 1'b1 || round_done !== 1'b1 || correct_cnt !== 5'(cnt_exp) || mistake !== 1'b0) begin
      fails++;
      $display("FAIL %s timeout: to=%0b done=%0b cnt=%0d mis=%0b, expected to=1 done=1 cnt=%0d mis=0",
               tag, timeout, round_done, correct_cnt, mistake, cnt_exp);
    end
    @(posedge clk);
    #1;
    tests++;
    if (round_done !== 1'b0 || busy !== 1'b0 || timeout !== 1'b1) begin
      fails++;
      $display("FAIL %s post timeout: done=%0b busy=%0b to=%0b, expected 0 0 1", tag, round_done, busy, timeout);
    end
  endtask

  function automatic logic [47:0] pat_3075();
    logic [47:0] p;
    p = 48'd0;
    p[2:0] = 3'd3; p[5:3] = 3'd0; p[8:6] = 3'd7; p[11:9] = 3'd5;
    return p;
  endfunction

  task automatic test_reset();
    logic [47:0] p;
    #3;
    tests++;
    if (leds !== 8'd0 || busy !== 1'b0 || round_done !== 1'b0 || correct_cnt !== 5'd0 || mistake !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset values: leds=%h busy=%0b done=%0b cnt=%0d mis=%0b to=%0b, expected all 0",
               leds, busy, round_done, correct_cnt, mistake, timeout);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    p = pat_3075();
    start_round(p, 5'd4, "reset_pre");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (leds !== 8'd0 || busy !== 1'b0 || round_done !== 1'b0 || correct_cnt !== 5'd0) begin
      fails++;
      $display("FAIL async reset: leds=%h busy=%0b done=%0b cnt=%0d, expected all 0", leds, busy, round_done, correct_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    start_round(p, 5'd4, "reset_restart");
    check_show(p, 4, 1'b0, "reset_restart");
    do_idle(0, 0, "reset_restart");
    $display("[TB] round reset_restart: replayed from step 0 and timed out");
  endtask

  task automatic test_full_round();
    logic [47:0] p;
    p = pat_3075();
    start_round(p, 5'd4, "full");
    check_show(p, 4, 1'b0, "full");
    do_press(oh(3), 0, 1, 1'b0, 1'b0, "full p0");
    do_press(oh(0), 1, 2, 1'b0, 1'b0, "full p1");
    do_press(oh(7), 2, 3, 1'b0, 1'b0, "full p2");
    do_press(oh(5), 3, 4, 1'b0, 1'b1, "full p3");
    $display("[TB] round full: cnt=%0d mistake=%0b timeout=%0b", correct_cnt, mistake, timeout);
  endtask

  task automatic test_wrong_press();
    logic [47:0] p;
    p = pat_3075();
    start_round(p, 5'd4, "wrong");
    check_show(p, 4, 1'b0, "wrong");
    do_press(oh(3), 0, 1, 1'b0, 1'b0, "wrong p0");
    do_press(oh(1), 1, 1, 1'b1, 1'b1, "wrong p1");
    $display("[TB] round wrong: cnt=%0d mistake=%0b", correct_cnt, mistake);
  endtask

  task automatic test_simultaneous();
    logic [47:0] p;
    p = 48'd0;
    p[2:0] = 3'd2;
    start_round(p, 5'd1, "multi");
    check_show(p, 1, 1'b0, "multi");
    do_press(oh(2) | oh(4), 0, 0, 1'b1, 1'b1, "multi p0");
    $display("[TB] round multi: cnt=%0d mistake=%0b", correct_cnt, mistake);
  endtask

  task automatic test_timeout();
    logic [47:0] p;
    p = rand_pat();
    start_round(p, 5'd2, "timeout");
    check_show(p, 2, 1'b0, "timeout");
    do_press(oh(int'(p[2:0])), 0, 1, 1'b0, 1'b0, "timeout p0");
    do_idle(1, 1, "timeout");
    $display("[TB] round timeout: cnt=%0d timeout=%0b", correct_cnt, timeout);
  endtask

  // Second press evaluated on the very edge the timeout would expire.
  task automatic test_press_beats_timeout();
    logic [47:0] p;
    p = rand_pat();
    start_round(p, 5'd2, "race");
    check_show(p, 2, 1'b0, "race");
    do_press(oh(int'(p[2:0])), 0, 1, 1'b0, 1'b0, "race p0");
    for (int k = 0; k < T - 4; k++) begin
      @(posedge clk);
      #1;
    end
    do_press(oh(int'(p[5:3])), 1, 2, 1'b0, 1'b1, "race p1");
    $display("[TB] round race: cnt=%0d timeout=%0b", correct_cnt, timeout);
  endtask

  task automatic test_ignore();
    logic [47:0] p;
    p = rand_pat();
    start_round(p, 5'd3, "ignore");
    check_show(p, 3, 1'b1, "ignore");
    buttons = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (correct_cnt !== 5'd0 || mistake !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ignore held: cnt=%0d mis=%0b busy=%0b, expected 0 0 1", correct_cnt, mistake, busy);
    end
    do_press(oh(int'(p[2:0])), 0, 1, 1'b0, 1'b0, "ignore p0");
    do_press(oh(int'(p[5:3])), 1, 2, 1'b0, 1'b0, "ignore p1");
    do_press(oh(int'(p[8:6])), 2, 3, 1'b0, 1'b1, "ignore p2");
    $display("[TB] round ignore: cnt=%0d mistake=%0b", correct_cnt, mistake);
  endtask

  task automatic test_len_zero();
    logic [47:0] p;
    p = rand_pat();
    start_round(p, 5'd0, "len0");
    check_show(p, 16, 1'b0, "len0");
    do_idle(0, 0, "len0");
    $display("[TB] round len0: 16 steps played, timeout=%0b", timeout);
  endtask

  // Consecutive random rounds, each started in the cycle right after DONE.
  task automatic test_back_to_back();
    logic [47:0] p;
    int raw, len, cnt, elapsed, roll;
    bit done;
    logic [2:0] step, other;
    for (int r = 0; r < 8; r++) begin
      p = rand_pat();
      raw = (r % 3 == 2) ? int'($urandom_range(17, 31)) : int'($urandom_range(1, 6));
      len = eff_len(raw);
      start_round(p, 5'(raw), "b2b");
      check_show(p, len, 1'b0, "b2b");
      cnt = 0;
      elapsed = 0;
      done = 1'b0;
      for (int i = 0; i < len && !done; i++) begin
        roll = int'($urandom_range(0, 11));
        step = p[3*i +: 3];
        other = 3'((int'(step) + int'($urandom_range(1, 7))) % 8);
        if (roll == 0) begin
          do_press(oh(int'(other)), cnt, cnt, 1'b1, 1'b1, "b2b wrong");
          done = 1'b1;
        end else if (roll == 1) begin
          do_press(oh(int'(step)) | oh(int'(other)), cnt, cnt, 1'b1, 1'b1, "b2b multi");
          done = 1'b1;
        end else if (roll == 2) begin
          do_idle(elapsed, cnt, "b2b idle");
          done = 1'b1;
        end else begin
          do_press(oh(int'(step)), cnt, cnt + 1, 1'b0, (cnt + 1 == len), "b2b ok");
          cnt++;
          elapsed = 1;
        end
      end
      $display("[TB] round b2b %0d: len=%0d cnt=%0d mistake=%0b timeout=%0b", r, len, correct_cnt, mistake, timeout);
    end
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_wrong_press();
    test_simultaneous();
    test_timeout();
    test_press_beats_timeout();
    test_ignore();
    test_len_zero();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pattern_player.md
# pattern_player

Round executor for the memory game, directly downstream of `pattern_generator`. On `start` it latches the generated pattern and the level-dependent length, then plays the steps on the 8 LEDs one at a time. It then collects player button presses and compares them step-by-step against the pattern. It reports a per-round result (correct count, mistake, timeout) to the game manager's scoring/round logic.

## Interface
Parameters:
- `SHOW_TICKS`, 25_000_000: cycles each step's LED stays lit.
- `GAP_TICKS`, 12_500_000: cycles all LEDs stay dark after each step.
- `TIMEOUT_TICKS`, 250_000_000: max cycles between input-phase presses.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse (driven from `pattern_gen_end`); honoured only in IDLE.
- `length` in 5: steps this round; legal 1..16; 0 or >16 treated as 16.
- `pattern_flat` in 48: step i at bits [3i+2:3i], value = LED/button index 0..7.
- `buttons` in 8: raw, active-high, debounced button levels (bit k = button k+1).
- `leds` out 8: LED drive, active-high.
- `busy` out 1: high in every state except IDLE.
- `round_done` out 1: one-cycle pulse when the result is final.
- `correct_cnt` out 5: steps matched this round.
- `mistake` out 1: a wrong or multi-button press ended the round.
- `timeout` out 1: press timeout ended the round.

## Operation
- States: IDLE, SHOW_ON, SHOW_GAP, INPUT, DONE.
- IDLE:
  - `leds`=0.
  - On `start`: latch `pattern_flat` and the clamped length, clear `correct_cnt`/`mistake`/`timeout`, set step index `idx`=0, load the tick counter, go to SHOW_ON.
- SHOW_ON:
  - `leds` = one-hot(pattern[idx]).
  - After SHOW_TICKS cycles go to SHOW_GAP.
- SHOW_GAP:
  - `leds`=0.
  - After GAP_TICKS cycles, if idx==len-1 go to INPUT with idx=0 and the timeout counter loaded; otherwise idx++ and go to SHOW_ON.
- Buttons during SHOW_ON/SHOW_GAP: press edges are discarded and the edge detector keeps tracking, so a button held across the SHOW→INPUT transition does not count.
- INPUT:
  - `leds` = synchronised `buttons` (echo).
  - A press event is a cycle with ≥1 rising edge on the synchronised buttons.
  - Exactly one edge, matching pattern[idx]: `correct_cnt`++, idx++, timeout counter reloaded. If the new idx==len go to DONE.
  - Exactly one edge, wrong index, or ≥2 simultaneous edges: `mistake`=1, go to DONE.
  - Timeout counter reaches 0 with no event: `timeout`=1, go to DONE.
  - A press event and timeout expiry in the same cycle: the press wins.
- DONE:
  - `round_done`=1 for one cycle, `leds`=0.
  - Next state is IDLE.
  - `correct_cnt`, `mistake`, `timeout` hold until the next accepted `start`.
- `start` outside IDLE is ignored; the latched pattern and length do not change mid-round.
- Reset mid-round: immediate return to IDLE with all outputs cleared; no `round_done`.
- Width rules:
  - `correct_cnt` ≤ len ≤ 16, so it never wraps.
  - Tick counters are sized to $clog2 of the largest parameter + 1.

## Timing
- Reset values: `leds`=0, `busy`=0, `round_done`=0, `correct_cnt`=0, `mistake`=0, `timeout`=0, state IDLE.
- All outputs are registered.
- `start` sampled high at edge t: `busy` and `leds` show step 0 from cycle t+1.
- Each step is lit for exactly SHOW_TICKS cycles and dark for exactly GAP_TICKS cycles.
- First INPUT cycle = t+1 + len·(SHOW_TICKS+GAP_TICKS).
- Button path is a 2-flop synchroniser plus an edge register. A rise on `buttons` before edge p is evaluated at edge p+2, and `correct_cnt`/`mistake` update visibly at p+3.
- `round_done` is asserted the cycle after the final INPUT evaluation. `busy` drops the cycle after `round_done`.
- Back-to-back: `start` arriving in the cycle after DONE (state IDLE) is accepted.

## Structure
- Shared package `game_pkg`:
  - state enum `player_state_t`
  - `MAX_STEPS`=16
  - `STEP_W`=3
  - helper function `onehot8(idx)`
- The same package later serves `pattern_generator` and the score logic.
- One natural sub-module: `btn_edge_sync` (8-bit 2-flop synchroniser + rising-edge detect, async active-low reset). The FSM, counters and compare stay in `pattern_player`.

## Test plan
Bench parameters for all scenarios: SHOW_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20.
- Reset check: assert `rst`=0 mid-SHOW_ON → all outputs 0 within the same cycle. Release and pulse `start` → playback restarts from step 0.
- Full correct round: length=4, steps 3,0,7,5. LEDs show 0x08,0x01,0x80,0x20, each for 4 cycles with 2 dark cycles between. Then press buttons 3,0,7,5 → `correct_cnt`=4, `mistake`=0, `round_done` pulse at p+3 after the last press.
- Wrong press: same pattern, press 3 then 1 → `correct_cnt`=1, `mistake`=1, `round_done` one pulse.
- Simultaneous press: length=1, press buttons 2 and 4 in the same cycle → `mistake`=1, `correct_cnt`=0.
- Timeout: length=2, correct first press, then idle → after exactly 20 cycles `timeout`=1, `correct_cnt`=1.
- Ignore rules:
  - Presses and a second `start` during SHOW → no count change and the latched pattern is kept.
  - length=0 → 16 steps played.
